// File: rtl/layernorm_seq_ctrl.sv
// rtl/layernorm_seq_ctrl.sv - three-pass (mean, variance, normalize) beat sequencer for the layer-norm datapath
module layernorm_seq_ctrl #(
  parameter int BUS_NUM        = 8,
  parameter int DATA_NUM_WIDTH = 10,
  parameter int ADDR_WIDTH     = 7,
  parameter int MAX_BEATS      = 97,
  parameter int MEAN_LAT       = 4,
  parameter int VAR_LAT        = 6,
  parameter int NORM_LAT       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_NUM_WIDTH-1:0] cfg_data_num,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic                      err_cfg,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [BUS_NUM-1:0]        rd_lane_mask,
  output logic [1:0]                phase,
  output logic                      beat_last,
  output logic                      gb_rd_en,
  output logic [ADDR_WIDTH-1:0]     gb_rd_addr,
  output logic                      mean_latch,
  output logic                      var_latch
);

  localparam int MAX_LAT = (MEAN_LAT > VAR_LAT) ? ((MEAN_LAT > NORM_LAT) ? MEAN_LAT : NORM_LAT)
                                                : ((VAR_LAT > NORM_LAT) ? VAR_LAT : NORM_LAT);
  localparam int WAIT_W  = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEAN_RD,
    S_MEAN_WAIT,
    S_VAR_RD,
    S_VAR_WAIT,
    S_NORM_RD,
    S_NORM_WAIT
  } state_t;

  state_t                      state, nxt_state;
  logic [ADDR_WIDTH-1:0]       cnt, nxt_cnt;
  logic [ADDR_WIDTH-1:0]       last_beat, nxt_last_beat;
  logic [WAIT_W-1:0]           wcnt, nxt_wcnt;
  logic [BUS_NUM-1:0]          last_mask, nxt_last_mask;
  logic [BUS_NUM-1:0]          nxt_mask;
  logic                        nxt_rd_en;
  logic                        nxt_err;
  logic [1:0]                  nxt_phase;

  logic [DATA_NUM_WIDTH-1:0]   cfg_rem;
  logic [DATA_NUM_WIDTH-1:0]   cfg_beats;
  logic                        cfg_bad;
  logic [BUS_NUM-1:0]          cfg_mask;

  // Beat count and partial-beat mask derived from the element count at start
  always_comb begin
    cfg_rem   = cfg_data_num % DATA_NUM_WIDTH'(BUS_NUM);
    cfg_beats = (cfg_data_num / DATA_NUM_WIDTH'(BUS_NUM))
              + ((cfg_rem != '0) ? DATA_NUM_WIDTH'(1) : DATA_NUM_WIDTH'(0));
    cfg_bad   = (cfg_data_num == '0) || (cfg_beats > DATA_NUM_WIDTH'(MAX_BEATS));
    for (int i = 0; i < BUS_NUM; i++) begin
      cfg_mask[i] = (cfg_rem == '0) || (DATA_NUM_WIDTH'(i) < cfg_rem);
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_wcnt      = wcnt;
    nxt_last_beat = last_beat;
    nxt_last_mask = last_mask;
    nxt_rd_en     = 1'b0;
    nxt_err       = 1'b0;
    if (abort) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
      nxt_wcnt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              nxt_err = 1'b1;
            end else begin
              nxt_state     = S_MEAN_RD;
              nxt_cnt       = '0;
              nxt_last_beat = ADDR_WIDTH'(cfg_beats - DATA_NUM_WIDTH'(1));
              nxt_last_mask = cfg_mask;
              nxt_rd_en     = 1'b1;
            end
          end
        end
        S_MEAN_RD: begin
          if (cnt == last_beat) begin
            nxt_state = S_MEAN_WAIT;
            nxt_cnt   = '0;
            nxt_wcnt  = '0;
          end else begin
            nxt_cnt   = cnt + ADDR_WIDTH'(1);
            nxt_rd_en = 1'b1;
          end
        end
        S_MEAN_WAIT: begin
          if (wcnt == WAIT_W'(MEAN_LAT - 1)) begin
            nxt_state = S_VAR_RD;
            nxt_cnt   = '0;
            nxt_rd_en = 1'b1;
          end else begin
            nxt_wcnt = wcnt + WAIT_W'(1);
          end
        end
        S_VAR_RD: begin
          if (cnt == last_beat) begin
            nxt_state = S_VAR_WAIT;
            nxt_cnt   = '0;
            nxt_wcnt  = '0;
          end else begin
            nxt_cnt   = cnt + ADDR_WIDTH'(1);
            nxt_rd_en = 1'b1;
          end
        end
        S_VAR_WAIT: begin
          if (wcnt == WAIT_W'(VAR_LAT - 1)) begin
            nxt_state = S_NORM_RD;
            nxt_cnt   = '0;
            nxt_rd_en = 1'b1;
          end else begin
            nxt_wcnt = wcnt + WAIT_W'(1);
          end
        end
        S_NORM_RD: begin
          // cnt is the pending beat; it only advances once the current one went out unstalled
          if (rd_en && (cnt == last_beat)) begin
            nxt_state = S_NORM_WAIT;
            nxt_cnt   = '0;
            nxt_wcnt  = '0;
          end else begin
            if (rd_en) begin
              nxt_cnt = cnt + ADDR_WIDTH'(1);
            end
            nxt_rd_en = !stall;
          end
        end
        S_NORM_WAIT: begin
          if (wcnt == WAIT_W'(NORM_LAT - 1)) begin
            nxt_state = S_IDLE;
            nxt_wcnt  = '0;
          end else begin
            nxt_wcnt = wcnt + WAIT_W'(1);
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_wcnt  = '0;
        end
      endcase
    end
  end

  // Output decode of the next state, registered below; a stalled NORM beat keeps its mask
  always_comb begin
    nxt_mask = '0;
    if ((nxt_state == S_MEAN_RD) || (nxt_state == S_VAR_RD) || (nxt_state == S_NORM_RD)) begin
      nxt_mask = (nxt_cnt == nxt_last_beat) ? nxt_last_mask : '1;
    end
    case (nxt_state)
      S_MEAN_RD, S_MEAN_WAIT: nxt_phase = 2'd0;
      S_VAR_RD, S_VAR_WAIT:   nxt_phase = 2'd1;
      S_NORM_RD, S_NORM_WAIT: nxt_phase = 2'd2;
      default:                nxt_phase = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wcnt         <= '0;
      last_beat    <= '0;
      last_mask    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_cfg      <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      rd_lane_mask <= '0;
      phase        <= 2'd3;
      beat_last    <= 1'b0;
      gb_rd_en     <= 1'b0;
      gb_rd_addr   <= '0;
      mean_latch   <= 1'b0;
      var_latch    <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      wcnt         <= nxt_wcnt;
      last_beat    <= nxt_last_beat;
      last_mask    <= nxt_last_mask;
      busy         <= (nxt_state != S_IDLE);
      done         <= (nxt_state == S_NORM_WAIT) && (nxt_wcnt == WAIT_W'(NORM_LAT - 1));
      err_cfg      <= nxt_err;
      rd_en        <= nxt_rd_en;
      rd_addr      <= nxt_cnt;
      rd_lane_mask <= nxt_mask;
      phase        <= nxt_phase;
      beat_last    <= nxt_rd_en && (nxt_cnt == nxt_last_beat);
      gb_rd_en     <= nxt_rd_en && (nxt_state == S_NORM_RD);
      gb_rd_addr   <= nxt_cnt;
      mean_latch   <= (nxt_state == S_MEAN_WAIT) && (nxt_wcnt == WAIT_W'(MEAN_LAT - 1));
      var_latch    <= (nxt_state == S_VAR_WAIT) && (nxt_wcnt == WAIT_W'(VAR_LAT - 1));
    end
  end

endmodule

// File: tb/tb_layernorm_seq_ctrl.sv
// tb/tb_layernorm_seq_ctrl.sv - directed self-checking bench for layernorm_seq_ctrl
module tb_layernorm_seq_ctrl;

  localparam int BUS_NUM        = 8;
  localparam int DATA_NUM_WIDTH = 10;
  localparam int ADDR_WIDTH     = 7;
  localparam int MAX_BEATS      = 97;
  localparam int MEAN_LAT       = 4;
  localparam int VAR_LAT        = 6;
  localparam int NORM_LAT       = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [DATA_NUM_WIDTH-1:0] cfg_data_num = '0;
  logic                      start = 1'b0;
  logic                      abort = 1'b0;
  logic                      stall = 1'b0;
  logic                      busy, done, err_cfg, rd_en, beat_last, gb_rd_en, mean_latch, var_latch;
  logic [ADDR_WIDTH-1:0]     rd_addr, gb_rd_addr;
  logic [BUS_NUM-1:0]        rd_lane_mask;
  logic [1:0]                phase;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  layernorm_seq_ctrl #(
    .BUS_NUM(BUS_NUM), .DATA_NUM_WIDTH(DATA_NUM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_BEATS(MAX_BEATS), .MEAN_LAT(MEAN_LAT), .VAR_LAT(VAR_LAT), .NORM_LAT(NORM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_data_num(cfg_data_num), .start(start), .abort(abort),
    .stall(stall), .busy(busy), .done(done), .err_cfg(err_cfg), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_lane_mask(rd_lane_mask), .phase(phase), .beat_last(beat_last),
    .gb_rd_en(gb_rd_en), .gb_rd_addr(gb_rd_addr), .mean_latch(mean_latch), .var_latch(var_latch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_cfg, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_mask"}, rd_lane_mask, 0);
    check({tag, "_phase"}, phase, 3);
    check({tag, "_beat_last"}, beat_last, 0);
    check({tag, "_gb_rd_en"}, gb_rd_en, 0);
    check({tag, "_latches"}, {mean_latch, var_latch}, 0);
  endtask

  // Start at cycle 0 and trace the whole job; stall high for cycles [stall_lo, stall_hi)
  task automatic run_job(input int n, input int stall_lo, input int stall_hi,
                         input bit stall_mean, input int extra_start, input int last_mask);
    int b, n_stall, mean_at, var_at, done_at, n_mean, n_var, n_done, p;
    int first_rd[3];
    int cnt_rd[3];
    int idx[3];
    bit fin;
    b = (n + BUS_NUM - 1) / BUS_NUM;
    n_stall = stall_hi - stall_lo;
    mean_at = 0; var_at = 0; done_at = 0; n_mean = 0; n_var = 0; n_done = 0; fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      first_rd[i] = 0; cnt_rd[i] = 0; idx[i] = 0;
    end
    cfg_data_num = DATA_NUM_WIDTH'(n);
    start = 1'b1;
    cyc_no = 0;
    while (!fin) begin
      tick();
      if (cyc_no == 1) check("busy_rise", busy, 1);
      if (rd_en) begin
        p = int'(phase);
        check("rd_phase_valid", p < 3, 1);
        if (p < 3) begin
          if (first_rd[p] == 0) first_rd[p] = cyc_no;
          cnt_rd[p]++;
          check("rd_addr", rd_addr, idx[p]);
          check("rd_mask", rd_lane_mask, (idx[p] == b - 1) ? last_mask : 8'hFF);
          check("beat_last", beat_last, idx[p] == b - 1);
          check("gb_rd_en", gb_rd_en, p == 2);
          check("gb_rd_addr", gb_rd_addr, idx[p]);
          idx[p]++;
        end
      end else begin
        check("gb_rd_en_idle", gb_rd_en, 0);
        check("beat_last_idle", beat_last, 0);
        if (phase != 2'd2) check("mask_idle", rd_lane_mask, 0);
      end
      if (n_stall > 0 && cyc_no > stall_lo && cyc_no <= stall_hi) begin
        check("stall_rd_en", rd_en, 0);
        check("stall_addr", rd_addr, idx[2]);
      end
      check("pulse_exclusive", int'(mean_latch) + int'(var_latch) + int'(done) <= 1, 1);
      if (mean_latch) begin n_mean++; if (mean_at == 0) mean_at = cyc_no; end
      if (var_latch)  begin n_var++;  if (var_at == 0)  var_at = cyc_no; end
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = cyc_no;
        check("busy_at_done", busy, 1);
      end
      stall = (cyc_no >= stall_lo && cyc_no < stall_hi) || (stall_mean && cyc_no <= b);
      start = (cyc_no == extra_start);
      if (done_at > 0 && cyc_no == done_at + 1) begin
        check("busy_fall", busy, 0);
        check("phase_end", phase, 3);
        fin = 1'b1;
      end else if (cyc_no >= 600) begin
        check("done_timeout", 0, 1);
        fin = 1'b1;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    check("first_rd_mean", first_rd[0], 1);
    check("first_rd_var", first_rd[1], b + MEAN_LAT + 1);
    check("first_rd_norm", first_rd[2], 2 * b + MEAN_LAT + VAR_LAT + 1);
    check("beats_mean", cnt_rd[0], b);
    check("beats_var", cnt_rd[1], b);
    check("beats_norm", cnt_rd[2], b);
    check("mean_latch_at", mean_at, b + MEAN_LAT);
    check("var_latch_at", var_at, 2 * b + MEAN_LAT + VAR_LAT);
    check("done_at", done_at, 3 * b + MEAN_LAT + VAR_LAT + NORM_LAT + n_stall);
    check("mean_latch_cnt", n_mean, 1);
    check("var_latch_cnt", n_var, 1);
    check("done_cnt", n_done, 1);
  endtask

  task automatic err_test(input int n);
    cfg_data_num = DATA_NUM_WIDTH'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", err_cfg, 1);
    check("err_busy", busy, 0);
    check("err_rd_en", rd_en, 0);
    tick();
    check("err_clear", err_cfg, 0);
    check("err_busy2", busy, 0);
    check("err_rd_en2", rd_en, 0);
    check("err_phase", phase, 3);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // N=16: B=2, full masks
    run_job(16, 0, 0, 1'b0, -1, 8'hFF);
    tick();
    // N=13: partial last beat
    run_job(13, 0, 0, 1'b0, -1, 8'h1F);
    tick();
    err_test(0);
    err_test(777);
    // N=776: B=97 is the largest accepted size
    run_job(776, 0, 0, 1'b0, -1, 8'hFF);
    tick();
    // N=24: stall across the second NORM beat plus stall during MEAN_RD
    run_job(24, 17, 20, 1'b1, -1, 8'hFF);
    tick();
    // Start while busy is ignored
    run_job(16, 0, 0, 1'b0, 5, 8'hFF);
    tick();

    // Abort on VAR beat 0, then restart one cycle later
    cfg_data_num = 10'd16;
    start = 1'b1;
    cyc_no = 0;
    while (cyc_no < 7) begin
      tick();
      start = 1'b0;
    end
    check("abort_pre_rd_en", rd_en, 1);
    check("abort_pre_phase", phase, 1);
    check("abort_pre_addr", rd_addr, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort");
    run_job(16, 0, 0, 1'b0, -1, 8'hFF);
    tick();

    // Reset in the middle of NORM_RD
    cfg_data_num = 10'd16;
    start = 1'b1;
    cyc_no = 0;
    while (cyc_no < 16) begin
      tick();
      start = 1'b0;
    end
    check("rst_pre_gb", gb_rd_en, 1);
    check("rst_pre_phase", phase, 2);
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    repeat (3) tick();
    check_idle_outputs("after_mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
